encoder_speed_meter: RTL and testbench

Measures motor shaft speed from a quadrature encoder and reports it in the same signed speed units and period convention that the speed-to-duty path consumes. It is the feedback end of the motor loop: the drive path turns a commanded speed into PWM on the motor pins, and this block turns encoder edges back into `period`, a signed `speed_400rpm` and a position count. `period == PERIOD_MAX` means "stalled / no measurement", which is the value the drive path's overload clamp keys on.

---
 rtl/encoder_speed_meter_if.sv | 16 +
 rtl/encoder_speed_meter.sv | 175 +++++++++++++++++
 tb/tb_encoder_speed_meter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_speed_meter_if.sv
// Encoder pins into the speed meter and its speed/position results back out.
interface encoder_speed_meter_if;
  logic               enc_a;
  logic               enc_b;
  logic signed [31:0] period;
  logic signed [31:0] speed_400rpm;
  logic               speed_valid;
  logic signed [31:0] position;
  logic               dir;
  logic               enc_err;

  modport master (output enc_a, enc_b,
                  input  period, speed_400rpm, speed_valid, position, dir, enc_err);
  modport slave  (input  enc_a, enc_b,
                  output period, speed_400rpm, speed_valid, position, dir, enc_err);
endinterface

// File: rtl/encoder_speed_meter.sv
// Quadrature encoder feedback: position count, A-rise period and signed speed = SPEED_K / period.
// period == PERIOD_MAX means stalled / no measurement.
module encoder_speed_meter #(
  parameter logic [31:0] SPEED_K     = 32'd1_000_000,
  parameter logic [31:0] PERIOD_MAX  = 32'h7fffffff,
  parameter logic [31:0] STALL_TICKS = 32'd2_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  encoder_speed_meter_if.slave  enc_if
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  logic                     r_a_s1, r_a_s2, r_a_prev;
  logic                     r_b_s1, r_b_s2, r_b_prev;
  logic [DATA_W-1:0]        r_pcnt;
  logic                     r_armed;
  logic                     r_stalled;
  state_t                   r_state;
  logic [4:0]               r_step;
  logic signed [DATA_W-1:0] r_period;
  logic signed [DATA_W-1:0] r_speed;
  logic                     r_valid;
  logic signed [DATA_W-1:0] r_pos;
  logic                     r_dir;
  logic                     r_err;

  logic [DATA_W-1:0]        r_dvd;
  logic [DATA_W-1:0]        r_dvs;
  logic [DATA_W-1:0]        r_rem;
  logic [DATA_W-1:0]        r_quo;

  logic                     w_a_rise, w_a_chg, w_b_chg, w_fwd;
  logic                     w_meas, w_stall;
  logic [DATA_W:0]          w_rem_sh;
  logic                     w_ge;
  logic [DATA_W-1:0]        w_rem_nx;
  logic [DATA_W-1:0]        w_quo_nx;

  // Clamp the unsigned quotient into the positive signed range, then apply direction.
  function automatic logic signed [DATA_W-1:0] f_signed_speed(input logic [DATA_W-1:0] q,
                                                              input logic neg);
    logic [DATA_W-1:0] mag;
    mag = (q > 32'h7fffffff) ? 32'h7fffffff : q;
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  assign w_a_chg  = r_a_s2 ^ r_a_prev;
  assign w_b_chg  = r_b_s2 ^ r_b_prev;
  assign w_a_rise = r_a_s2 & ~r_a_prev;
  // A leading B counts up, so B low at an A rise (dir = 0) matches a rising position.
  assign w_fwd    = w_a_chg ? (r_a_s2 ^ r_b_s2) : ~(r_a_s2 ^ r_b_s2);

  assign w_meas   = w_a_rise & r_armed;
  assign w_stall  = (r_pcnt == STALL_TICKS) & ~w_a_rise & ~r_stalled;

  assign w_rem_sh = {r_rem, r_dvd[DATA_W-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nx = w_ge ? DATA_W'(w_rem_sh - {1'b0, r_dvs}) : w_rem_sh[DATA_W-1:0];
  assign w_quo_nx = {r_quo[DATA_W-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_s1    <= 1'b0;
      r_a_s2    <= 1'b0;
      r_a_prev  <= 1'b0;
      r_b_s1    <= 1'b0;
      r_b_s2    <= 1'b0;
      r_b_prev  <= 1'b0;
      r_pcnt    <= 32'd1;
      r_armed   <= 1'b0;
      r_stalled <= 1'b0;
      r_state   <= S_IDLE;
      r_step    <= 5'd0;
      r_period  <= PERIOD_MAX;
      r_speed   <= '0;
      r_valid   <= 1'b0;
      r_pos     <= '0;
      r_dir     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // Stage boundary: pin synchronisers and previous-state register for edge detection.
      r_a_s1   <= enc_if.enc_a;
      r_a_s2   <= r_a_s1;
      r_a_prev <= r_a_s2;
      r_b_s1   <= enc_if.enc_b;
      r_b_s2   <= r_b_s1;
      r_b_prev <= r_b_s2;

      r_err   <= 1'b0;
      r_valid <= 1'b0;
      if (w_a_chg && w_b_chg)
        r_err <= 1'b1;
      else if (w_a_chg || w_b_chg)
        r_pos <= w_fwd ? r_pos + 32'sd1 : r_pos - 32'sd1;

      if (w_a_rise) begin
        r_pcnt    <= 32'd1;
        r_armed   <= 1'b1;
        r_stalled <= 1'b0;
      end else if (r_pcnt != STALL_TICKS) begin
        r_pcnt <= r_pcnt + 32'd1;
      end

      if (w_stall) begin
        r_stalled <= 1'b1;
        r_armed   <= 1'b0;
        r_period  <= PERIOD_MAX;
        r_speed   <= '0;
        r_valid   <= 1'b1;
        r_state   <= S_IDLE;
      end else begin
        if (w_meas) begin
          r_period <= $signed(r_pcnt);
          r_dir    <= r_b_s2;
        end
        // Stage boundary: divider control; a fresh measurement always restarts it.
        case (r_state)
          S_IDLE: begin
            if (w_meas) begin
              r_state <= S_DIV;
              r_step  <= 5'd0;
            end
          end
          S_DIV: begin
            if (w_meas) begin
              r_step <= 5'd0;
            end else begin
              r_step <= r_step + 5'd1;
              if (r_step == 5'd31) begin
                r_state <= S_DONE;
                r_speed <= f_signed_speed(w_quo_nx, r_dir);
                r_valid <= 1'b1;
              end
            end
          end
          S_DONE: begin
            if (w_meas) begin
              r_state <= S_DIV;
              r_step  <= 5'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Stage boundary: restoring-division datapath, one quotient bit per cycle.
  always_ff @(posedge clk) begin
    if (w_meas) begin
      r_dvd <= SPEED_K;
      r_dvs <= r_pcnt;
      r_rem <= '0;
      r_quo <= '0;
    end else if (r_state == S_DIV) begin
      r_dvd <= {r_dvd[DATA_W-2:0], 1'b0};
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
    end
  end

  assign enc_if.period       = r_period;
  assign enc_if.speed_400rpm = r_speed;
  assign enc_if.speed_valid  = r_valid;
  assign enc_if.position     = r_pos;
  assign enc_if.dir          = r_dir;
  assign enc_if.enc_err      = r_err;

endmodule

// File: tb/tb_encoder_speed_meter.sv
// Bench for encoder_speed_meter: directed phases with randomized spacing, checked against an event model.
module tb_encoder_speed_meter;

  localparam logic [31:0] K     = 32'd1_000_000;
  localparam logic [31:0] PMAX  = 32'h7fffffff;
  localparam int          STALL = 1000;
  localparam int          KI    = 1_000_000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  encoder_speed_meter_if ifc();

  encoder_speed_meter #(
    .SPEED_K    (K),
    .PERIOD_MAX (PMAX),
    .STALL_TICKS(32'(STALL))
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enc_if (ifc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                 c;
    logic signed [31:0] spd;
    logic signed [31:0] per;
    int                 d;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  obs_err = 0;

  int total = 0;
  int bad   = 0;

  int   m_pos = 0;
  int   exp_err = 0;
  bit   m_armed = 0;
  bit   m_stalled = 0;
  int   m_last = -1;
  int   pend_c = -1;
  logic m_a = 1'b0;
  logic m_b = 1'b0;
  bit   in_rst = 1;

  always @(negedge clk) begin
    if (ifc.speed_valid === 1'b1)
      obs_q.push_back('{cyc, ifc.speed_400rpm, ifc.period, int'(ifc.dir)});
    if (ifc.enc_err === 1'b1)
      obs_err++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Position in the forward cycle 00 -> 10 -> 11 -> 01 of pins (A,B).
  function automatic int gidx(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_rise(input int c, input logic b);
    int s;
    s = c - m_last;
    if (m_last >= 0 && !m_stalled && s > STALL) begin
      exp_q.push_back('{m_last + STALL + 3, 32'sd0, PMAX, 2});
      m_armed = 0;
    end
    if (m_armed) begin
      if (pend_c >= c + 3) void'(exp_q.pop_back());
      exp_q.push_back('{c + 35, b ? -(KI / s) : (KI / s), s, int'(b)});
      pend_c = c + 35;
    end
    m_armed   = 1;
    m_stalled = 0;
    m_last    = c;
  endtask

  task automatic drive(input logic a, input logic b);
    int d;
    @(posedge clk);
    #1;
    if (!in_rst) begin
      d = (gidx(a, b) - gidx(m_a, m_b)) & 3;
      if (d == 1) m_pos++;
      else if (d == 3) m_pos--;
      else if (d == 2) exp_err++;
      if (a && !m_a) model_rise(cyc, b);
    end
    ifc.enc_a = a;
    ifc.enc_b = b;
    m_a = a;
    m_b = b;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic quad(input bit rev, input int q1, input int q2, input int q3, input int q4);
    if (!rev) begin
      drive(1'b1, 1'b0); idle(q1 - 1);
      drive(1'b1, 1'b1); idle(q2 - 1);
      drive(1'b0, 1'b1); idle(q3 - 1);
      drive(1'b0, 1'b0); idle(q4 - 1);
    end else begin
      drive(1'b0, 1'b1); idle(q1 - 1);
      drive(1'b1, 1'b1); idle(q2 - 1);
      drive(1'b1, 1'b0); idle(q3 - 1);
      drive(1'b0, 1'b0); idle(q4 - 1);
    end
  endtask

  task automatic quad_rand(input bit rev, input int p);
    int base, q1, q2, q3;
    base = p / 4;
    q1 = base - 1 + int'($urandom_range(0, 2));
    q2 = base - 1 + int'($urandom_range(0, 2));
    q3 = base - 1 + int'($urandom_range(0, 2));
    quad(rev, q1, q2, q3, p - q1 - q2 - q3);
  endtask

  task automatic check_events(input string tag);
    ev_t e, o;
    if (m_last >= 0 && !m_stalled && cyc > m_last + STALL + 3) begin
      exp_q.push_back('{m_last + STALL + 3, 32'sd0, PMAX, 2});
      m_stalled = 1;
      m_armed   = 0;
    end
    while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        chk({tag, "_valid_missing_at"}, -1, e.c);
      end else begin
        o = obs_q.pop_front();
        chk({tag, "_valid_cycle"}, o.c, e.c);
        chk({tag, "_speed"}, o.spd, e.spd);
        chk({tag, "_period"}, o.per, e.per);
        if (e.d != 2) chk({tag, "_dir"}, o.d, e.d);
      end
    end
    chk({tag, "_extra_valids"}, obs_q.size(), 0);
    obs_q.delete();
    chk({tag, "_err_count"}, obs_err, exp_err);
    chk({tag, "_position"}, ifc.position, m_pos);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_period"}, ifc.period, PMAX);
    chk({tag, "_speed"}, ifc.speed_400rpm, 0);
    chk({tag, "_position"}, ifc.position, 0);
    chk({tag, "_dir"}, {31'b0, ifc.dir}, 0);
    chk({tag, "_valid"}, {31'b0, ifc.speed_valid}, 0);
    chk({tag, "_err"}, {31'b0, ifc.enc_err}, 0);
  endtask

  initial begin
    int p;
    int pre;
    ifc.enc_a = 1'b0;
    ifc.enc_b = 1'b0;

    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk_reset_vals("reset_hold");
    end
    drive(1'b0, 1'b0);
    idle(3);
    rst_n  = 1'b1;
    in_rst = 0;
    m_a = 1'b0;
    m_b = 1'b0;
    idle(4);

    for (int i = 0; i < 4; i++) quad(1'b0, 50, 50, 50, 50);
    idle(5);
    check_events("fwd200");
    chk("fwd200_speed_now", ifc.speed_400rpm, 5000);
    chk("fwd200_period_now", ifc.period, 200);
    chk("fwd200_pos_now", ifc.position, 16);

    for (int i = 0; i < 4; i++) quad(1'b1, 50, 50, 50, 50);
    idle(5);
    check_events("rev200");
    chk("rev200_speed_now", ifc.speed_400rpm, -5000);
    chk("rev200_dir_now", {31'b0, ifc.dir}, 1);
    chk("rev200_pos_now", ifc.position, 0);

    for (int i = 0; i < 8; i++) begin
      p = int'($urandom_range(40, 400));
      quad_rand(1'($urandom_range(0, 1)), p);
    end
    idle(5);
    check_events("random");

    quad(1'b0, 15, 15, 15, 15);
    quad(1'b0, 8, 8, 8, 9);
    quad(1'b0, 15, 15, 15, 15);
    quad(1'b0, 8, 8, 8, 8);
    quad(1'b0, 15, 15, 15, 15);
    idle(5);
    check_events("spacing33");

    for (int i = 0; i < 5; i++) quad(1'b0, 5, 5, 5, 5);
    check_events("restart20");
    for (int i = 0; i < 3; i++) quad(1'b0, 25, 25, 25, 25);
    idle(5);
    check_events("restart100");
    chk("restart100_speed_now", ifc.speed_400rpm, 10000);

    quad(1'b0, 250, 250, 250, 250);
    drive(1'b1, 1'b0);
    idle(40);
    check_events("spacing1000");
    chk("spacing1000_speed_now", ifc.speed_400rpm, 1000);
    drive(1'b1, 1'b1); idle(4);
    drive(1'b0, 1'b1); idle(4);
    drive(1'b0, 1'b0); idle(4);

    pre = m_pos;
    drive(1'b1, 1'b1);
    idle(5);
    chk("illegal_pos_hold", ifc.position, pre);
    chk("illegal_err_count", obs_err, exp_err);
    drive(1'b0, 1'b1); idle(3);
    drive(1'b0, 1'b0); idle(40);
    check_events("illegal");

    quad(1'b0, 15, 15, 15, 15);
    quad(1'b0, 15, 15, 15, 15);
    idle(1100);
    check_events("stall");
    chk("stall_period_now", ifc.period, PMAX);
    chk("stall_speed_now", ifc.speed_400rpm, 0);
    idle(500);
    check_events("stall_hold");
    for (int i = 0; i < 3; i++) quad(1'b0, 20, 20, 20, 20);
    idle(5);
    check_events("post_stall");

    quad(1'b0, 20, 20, 20, 20);
    drive(1'b1, 1'b0);
    idle(9);
    #1;
    rst_n  = 1'b0;
    in_rst = 1;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].c >= cyc) exp_q.delete(i);
    m_armed = 0; m_stalled = 0; m_last = -1; pend_c = -1; m_pos = 0;
    #1;
    chk_reset_vals("reset_mid_div");
    drive(1'b0, 1'b0);
    idle(3);
    rst_n  = 1'b1;
    in_rst = 0;
    m_a = 1'b0;
    m_b = 1'b0;
    idle(50);
    check_events("after_reset");
    quad(1'b0, 20, 20, 20, 20);
    quad(1'b0, 20, 20, 20, 20);
    idle(5);
    check_events("rearm_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
